wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port behind the WB stage. Shares it between the
//  in-order pipeline writeback (the WB_res path) and the multi-cycle mul/div unit (MDU).
//  MDU results queue in a small skid FIFO. The pipeline has priority, with a starvation bound.

---
 rtl/wb_port_arbiter_pkg.sv | 11 +
 rtl/wb_skid_fifo.sv | 75 +++++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: grant encoding for the single
// register-file write port.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small circular queue for MDU results. Exposes the destination field of every
// slot plus a per-slot valid mask so the top level can run hazard compares.
module wb_skid_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned DEST_W = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0]             tap_valid,
  output logic [DEST_W-1:0]            tap_dest [DEPTH]
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    offset;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    tap_valid = '0;
    offset    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset       = AW'(i) - rd_q;
      tap_valid[i] = CW'(offset) < count_q;
      tap_dest[i]  = mem_q[i][WIDTH-1 -: DEST_W];
    end
  end

  assign rdata = mem_q[rd_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and queued
// MDU results; pipeline wins unless the MDU head has waited MAX_WAIT cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RADDR_W    = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipe_wb_valid,
  input  logic [RADDR_W-1:0] pipe_wb_dest,
  input  logic [DATA_W-1:0]  pipe_wb_data,
  output logic               pipe_stall,
  input  logic               mdu_valid,
  output logic               mdu_ready,
  input  logic [RADDR_W-1:0] mdu_dest,
  input  logic [DATA_W-1:0]  mdu_data,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic [RADDR_W-1:0] id_dest,
  output logic               id_hazard,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = RADDR_W + DATA_W;

  grant_e              gnt;
  logic                push, pop, empty;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head;
  logic [FIFO_DEPTH-1:0] tap_valid;
  logic [RADDR_W-1:0]  tap_dest [FIFO_DEPTH];
  logic [RADDR_W-1:0]  head_dest;
  logic [DATA_W-1:0]   head_data;

  logic [WW-1:0]       wait_q, wait_d;
  logic                rf_we_q, rf_we_d;
  logic [RADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  wb_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (EW),
    .DEST_W (RADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     ({mdu_dest, mdu_data}),
    .rdata     (head),
    .empty     (empty),
    .count     (count),
    .tap_valid (tap_valid),
    .tap_dest  (tap_dest)
  );

  assign head_dest = head[EW-1 -: RADDR_W];
  assign head_data = head[DATA_W-1:0];
  assign mdu_ready = (count != CW'(FIFO_DEPTH));
  assign push      = mdu_valid && mdu_ready;
  assign pop       = (gnt == GNT_MDU);
  assign pipe_stall = pipe_wb_valid && (gnt == GNT_MDU);

  always_comb begin
    gnt = GNT_NONE;
    if (!empty && (!pipe_wb_valid || wait_q == WW'(MAX_WAIT))) gnt = GNT_MDU;
    else if (pipe_wb_valid)                                    gnt = GNT_PIPE;
  end

  always_comb begin
    wait_d = wait_q;
    if (empty || gnt == GNT_MDU)     wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT)) wait_d = wait_q + WW'(1);
  end

  // Writes to R0 still consume the grant; only the write enable is suppressed.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (gnt)
      GNT_PIPE: begin
        rf_we_d    = (pipe_wb_dest != '0);
        rf_waddr_d = pipe_wb_dest;
        rf_wdata_d = pipe_wb_data;
      end
      GNT_MDU: begin
        rf_we_d    = (head_dest != '0);
        rf_waddr_d = head_dest;
        rf_wdata_d = head_data;
      end
      default: ;
    endcase
  end

  // Entries popped this cycle still match: their write lands on the next edge.
  always_comb begin
    id_hazard = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (tap_valid[i] && tap_dest[i] != '0 &&
          (tap_dest[i] == id_src1 || tap_dest[i] == id_src2 || tap_dest[i] == id_dest))
        id_hazard = 1'b1;
    end
    if (push && mdu_dest != '0 &&
        (mdu_dest == id_src1 || mdu_dest == id_src2 || mdu_dest == id_dest))
      id_hazard = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every register-file write (with its cycle) and the combinational handshakes.
module tb_wb_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 2;
  localparam int MAXW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_wb_valid = 1'b0;
  logic [AW-1:0] pipe_wb_dest = '0;
  logic [DW-1:0] pipe_wb_data = '0;
  logic          pipe_stall;
  logic          mdu_valid = 1'b0;
  logic          mdu_ready;
  logic [AW-1:0] mdu_dest = '0;
  logic [DW-1:0] mdu_data = '0;
  logic [AW-1:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic          id_hazard;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  wb_port_arbiter #(
    .DATA_W     (DW),
    .RADDR_W    (AW),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_dest  (pipe_wb_dest),
    .pipe_wb_data  (pipe_wb_data),
    .pipe_stall    (pipe_stall),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_dest      (mdu_dest),
    .mdu_data      (mdu_data),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_dest       (id_dest),
    .id_hazard     (id_hazard),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [AW-1:0] d; logic [DW-1:0] v; } ent_t;
  typedef struct packed { int c; logic [AW-1:0] a; logic [DW-1:0] v; } wr_t;

  ent_t mq[$];
  wr_t  eq[$];
  int   starve = 0;
  bit   m_stall = 0, m_acc = 1;

  int n_chk = 0, n_pass = 0;

  logic          s_pv = 0, s_mv = 0;
  logic [AW-1:0] s_pd = 0, s_md = 0, s_1 = 0, s_2 = 0, s_d = 0;
  logic [DW-1:0] s_pdat = 0, s_mdat = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic bit hits(input logic [AW-1:0] d);
    return d != 0 && (d == s_1 || d == s_2 || d == s_d);
  endfunction

  // One clock: apply stimulus after the edge, then predict and compare.
  task automatic step();
    int n, g;
    bit rdy, psh, haz;
    ent_t e;
    @(posedge clk);
    #1;
    pipe_wb_valid = s_pv; pipe_wb_dest = s_pd; pipe_wb_data = s_pdat;
    mdu_valid = s_mv; mdu_dest = s_md; mdu_data = s_mdat;
    id_src1 = s_1; id_src2 = s_2; id_dest = s_d;
    #1;
    n   = mq.size();
    rdy = n < DEPTH;
    psh = s_mv && rdy;
    if (n > 0 && (!s_pv || starve == MAXW)) g = 2;
    else if (s_pv) g = 1;
    else g = 0;
    haz = psh && hits(s_md);
    foreach (mq[i]) if (hits(mq[i].d)) haz = 1;
    chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, rdy});
    chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, s_pv && g == 2});
    chk("id_hazard", {31'd0, id_hazard}, {31'd0, haz});
    if (g == 2) begin
      e = mq.pop_front();
      if (e.d != 0) eq.push_back('{c: cyc + 1, a: e.d, v: e.v});
    end else if (g == 1 && s_pd != 0) begin
      eq.push_back('{c: cyc + 1, a: s_pd, v: s_pdat});
    end
    if (n == 0 || g == 2) starve = 0;
    else if (starve < MAXW) starve++;
    if (psh) mq.push_back('{d: s_md, v: s_mdat});
    m_stall = s_pv && g == 2;
    m_acc   = psh;
  endtask

  // Random traffic that honours the hold rules of both producers.
  task automatic rnd(input int pp, input int mp);
    if (!(s_pv && m_stall)) begin
      s_pv = $urandom_range(99) < pp; s_pd = AW'($urandom); s_pdat = DW'($urandom);
    end
    if (!(s_mv && !m_acc)) begin
      s_mv = $urandom_range(99) < mp; s_md = AW'($urandom); s_mdat = DW'($urandom);
    end
    s_1 = AW'($urandom); s_2 = AW'($urandom); s_d = AW'($urandom);
  endtask

  task automatic idle();
    s_pv = 0; s_mv = 0; s_1 = 0; s_2 = 0; s_d = 0;
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      while (eq.size() > 0 && eq[0].c < cyc) begin
        w = eq.pop_front();
        chk("missed_write", 32'd0, 32'd1);
      end
      if (rf_we) begin
        if (eq.size() == 0) chk("unexpected_write", {29'd0, rf_waddr}, 32'd0);
        else begin
          w = eq.pop_front();
          chk("write_cycle", cyc, w.c);
          chk("rf_waddr", {29'd0, rf_waddr}, {29'd0, w.a});
          chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, w.v});
        end
      end
    end
  end

  task automatic reset_checks();
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    chk("rst_id_hazard", {31'd0, id_hazard}, 32'd0);
    chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
  endtask

  initial begin
    int k;
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;

    // Pipe-only write to r3.
    s_pv = 1; s_pd = 3; s_pdat = 16'h1234; step();
    idle(); step();

    // MDU result in an idle slot; hazard on src1 until the pop cycle.
    s_mv = 1; s_md = 5; s_mdat = 16'hBEEF; s_1 = 5; step();
    s_mv = 0; step();
    step();
    idle(); step();

    // Starvation: one MDU entry against continuous pipe traffic.
    s_mv = 1; s_md = 6; s_mdat = 16'h6666; s_pv = 1; s_pd = 1; s_pdat = 16'h0100; step();
    s_mv = 0;
    for (int i = 0; i < 7; i++) begin
      if (!m_stall) begin s_pd = AW'(1 + i % 7); s_pdat = DW'(16'h0200 + i); end
      step();
    end
    idle(); step(); step();

    // Full queue: three MDU results while the pipe is busy.
    k = 0;
    s_pv = 1; s_pd = 2; s_pdat = 16'h2000;
    for (int i = 0; i < 14; i++) begin
      s_mv = k < 3; s_md = AW'(4 + k); s_mdat = DW'(16'hA000 + k);
      step();
      if (m_acc) k++;
      if (!m_stall) begin s_pd = AW'(1 + i % 7); s_pdat = DW'(16'h3000 + i); end
    end
    idle(); repeat (4) step();

    // R0 destination: popped silently, never a hazard for src 0.
    s_mv = 1; s_md = 0; s_mdat = 16'hDEAD; step();
    s_mv = 0; step();
    step();

    // Reset with queued traffic.
    s_pv = 1; s_pd = 7; s_pdat = 16'h7777; s_mv = 1; s_md = 4; s_mdat = 16'h4444; s_1 = 4;
    step();
    s_md = 3; s_mdat = 16'h3333; step();
    @(negedge clk);
    #1 rst_n = 0;
    pipe_wb_valid = 0; mdu_valid = 0;
    #1;
    reset_checks();
    mq.delete(); eq.delete(); starve = 0; m_stall = 0; m_acc = 1;
    idle();
    @(negedge clk);
    #1 rst_n = 1;
    step(); step();

    // Randomized traffic at several load mixes.
    for (int i = 0; i < 400; i++) begin
      rnd(i < 200 ? 80 : 40, i < 200 ? 50 : 90);
      step();
    end
    idle(); repeat (10) step();
    @(negedge clk);
    #1;
    chk("drain_expected", eq.size(), 32'd0);
    chk("drain_queue", mq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
